// File: rtl/even_sweep_ctrl.sv
// even_sweep_ctrl: sweeps lo..hi through an external even checker and tallies even/odd replies
module even_sweep_ctrl #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] lo,
  input  logic [W-1:0] hi,
  input  logic         abort,
  output logic [W-1:0] chk_num,
  output logic         chk_valid,
  input  logic         chk_result,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W:0]   even_cnt,
  output logic [W:0]   odd_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [W-1:0] cur, hi_q;
  logic accept, last;
  assign accept = state == IDLE && start;
  assign last = cur == hi_q;
  // state register
  always_ff @(posedge clk) state <= reset ? IDLE : state_nx;
  // next state and state-decoded outputs; abort wins over the final-cycle exit
  always_comb begin
    state_nx = IDLE;
    if (accept) state_nx = lo <= hi ? RUN : DONE;
    else if (state == RUN) state_nx = abort ? IDLE : last ? DONE : RUN;
    busy = state == RUN;
    chk_valid = state == RUN;
    done = state == DONE;
    chk_num = cur;
  end
  // sweep datapath: cur walks lo..hi and parks on the last number shown, so hi=max never wraps
  always_ff @(posedge clk) begin
    if (reset) begin
      cur <= '0;
      hi_q <= '0;
      err <= 1'b0;
      even_cnt <= '0;
      odd_cnt <= '0;
    end else if (accept) begin
      even_cnt <= '0;
      odd_cnt <= '0;
      err <= lo > hi;
      if (lo <= hi) begin
        cur <= lo;
        hi_q <= hi;
      end
    end else if (state == RUN) begin
      even_cnt <= even_cnt + {{W{1'b0}}, chk_result};
      odd_cnt <= odd_cnt + {{W{1'b0}}, ~chk_result};
      if (!abort && !last) cur <= cur + 1'b1;
    end
  end
endmodule

// File: tb/tb_even_sweep_ctrl.sv
// tb_even_sweep_ctrl: randomized sweeps checked against an arithmetic model of the sweep
module tb_even_sweep_ctrl;
  localparam int W = 8;
  logic clk = 0, reset = 0, start = 0, abort = 0;
  logic [W-1:0] lo = '0, hi = '0;
  logic [W-1:0] chk_num;
  logic chk_valid, chk_result, busy, done, err;
  logic [W:0] even_cnt, odd_cnt;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;
  assign chk_result = ~chk_num[0];

  even_sweep_ctrl #(.W(W)) dut (
    .clk(clk), .reset(reset), .start(start), .lo(lo), .hi(hi), .abort(abort),
    .chk_num(chk_num), .chk_valid(chk_valid), .chk_result(chk_result),
    .busy(busy), .done(done), .err(err), .even_cnt(even_cnt), .odd_cnt(odd_cnt)
  );

  logic [W-1:0] obs_nums[$];
  int obs_done_at, obs_done_n, obs_idle_at, obs_bad_flags;
  logic obs_timeout, obs_err;
  logic [W:0] obs_even, obs_odd;

  logic [W-1:0] exp_nums[$];
  int exp_done_at, exp_idle_at;
  logic exp_err;
  logic [W:0] exp_even, exp_odd;

  // reference: the numbers a sweep of lo..hi shows, cut short by an abort in RUN cycle ab (0 = none)
  task automatic model(input int l, input int h, input int ab);
    int n;
    bit aborted;
    exp_nums.delete();
    exp_even = '0;
    exp_odd = '0;
    exp_err = l > h;
    if (l > h) begin
      exp_done_at = 1;
      exp_idle_at = 2;
      return;
    end
    n = h - l + 1;
    aborted = ab >= 1 && ab <= n;
    if (aborted) n = ab;
    for (int i = 0; i < n; i++) begin
      exp_nums.push_back(W'(l + i));
      if ((l + i) % 2 == 0) exp_even++;
      else exp_odd++;
    end
    exp_done_at = aborted ? 0 : n + 1;
    exp_idle_at = aborted ? n + 1 : n + 2;
  endtask

  // drives one start and records what the DUT shows until it is back in IDLE; no checking here
  task automatic sweep(input int l, input int h, input int ab, input bit noise, input bit idle_abort, input bit now);
    int runs;
    obs_nums.delete();
    obs_done_at = 0;
    obs_done_n = 0;
    obs_idle_at = 0;
    obs_bad_flags = 0;
    obs_timeout = 1;
    runs = 0;
    if (!now) @(negedge clk);
    start = 1;
    lo = W'(l);
    hi = W'(h);
    abort = idle_abort;
    for (int k = 1; k <= 600; k++) begin
      @(negedge clk);
      start = 0;
      abort = 0;
      if (noise) begin
        lo = W'($urandom);
        hi = W'($urandom);
      end
      if (busy !== chk_valid) obs_bad_flags++;
      if (done === 1'b1 && (busy !== 1'b0 || chk_valid !== 1'b0)) obs_bad_flags++;
      if (chk_valid === 1'b1) begin
        obs_nums.push_back(chk_num);
        runs++;
        if (runs == ab) abort = 1;
        if (noise && $urandom_range(0, 2) == 0) start = 1;
      end
      if (done === 1'b1) begin
        obs_done_n++;
        obs_done_at = k;
        if (noise) begin
          start = 1;
          abort = 1;
        end
      end
      if (busy === 1'b0 && done === 1'b0) begin
        obs_idle_at = k;
        obs_even = even_cnt;
        obs_odd = odd_cnt;
        obs_err = err;
        obs_timeout = 0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1;
    start = 1;
    abort = 1;
    lo = 8'd3;
    hi = 8'd9;
    repeat (2) @(negedge clk);
    reset = 0;
    start = 0;
    abort = 0;
    checks++; if ({chk_num, chk_valid, busy, done, err} !== '0) begin errors++; $display("FAIL reset_outs got %h want 0", {chk_num, chk_valid, busy, done, err}); end
    checks++; if ({even_cnt, odd_cnt} !== '0) begin errors++; $display("FAIL reset_cnts got %h want 0", {even_cnt, odd_cnt}); end
  endtask

  task automatic test_basic;
    model(0, 9, 0);
    sweep(0, 9, 0, 1, 0, 0);
    checks++; if (obs_timeout !== 0) begin errors++; $display("FAIL basic_timeout got %0d want 0", obs_timeout); end
    checks++; if (obs_nums.size() != 10) begin errors++; $display("FAIL basic_len got %0d want 10", obs_nums.size()); end
    for (int i = 0; i < obs_nums.size() && i < exp_nums.size(); i++) begin
      checks++; if (obs_nums[i] !== exp_nums[i]) begin errors++; $display("FAIL basic_num[%0d] got %0d want %0d", i, obs_nums[i], exp_nums[i]); end
    end
    checks++; if (obs_done_at != 11 || obs_done_n != 1) begin errors++; $display("FAIL basic_done got at=%0d n=%0d want at=11 n=1", obs_done_at, obs_done_n); end
    checks++; if (obs_idle_at != 12) begin errors++; $display("FAIL basic_idle got %0d want 12", obs_idle_at); end
    checks++; if (obs_even !== 9'd5 || obs_odd !== 9'd5 || obs_err !== 1'b0) begin errors++; $display("FAIL basic_cnts got %0d/%0d err=%0d want 5/5 err=0", obs_even, obs_odd, obs_err); end
    checks++; if (obs_bad_flags != 0) begin errors++; $display("FAIL basic_flags got %0d want 0", obs_bad_flags); end
    repeat (3) @(negedge clk);
    checks++; if (even_cnt !== 9'd5 || odd_cnt !== 9'd5 || chk_num !== 8'd9 || busy !== 1'b0) begin errors++; $display("FAIL basic_hold got %0d/%0d num=%0d busy=%0d want 5/5 num=9 busy=0", even_cnt, odd_cnt, chk_num, busy); end
  endtask

  task automatic test_single;
    sweep(7, 7, 0, 0, 0, 0);
    checks++; if (obs_nums.size() != 1 || obs_nums.size() == 1 && obs_nums[0] !== 8'd7) begin errors++; $display("FAIL single_nums got len=%0d want len=1 num=7", obs_nums.size()); end
    checks++; if (obs_done_at != 2 || obs_idle_at != 3) begin errors++; $display("FAIL single_timing got done=%0d idle=%0d want 2/3", obs_done_at, obs_idle_at); end
    checks++; if (obs_even !== 9'd0 || obs_odd !== 9'd1) begin errors++; $display("FAIL single_cnts got %0d/%0d want 0/1", obs_even, obs_odd); end
  endtask

  task automatic test_full;
    model(0, 255, 0);
    sweep(0, 255, 0, 0, 0, 0);
    checks++; if (obs_nums.size() != 256) begin errors++; $display("FAIL full_len got %0d want 256", obs_nums.size()); end
    checks++; if (obs_nums.size() > 0 && obs_nums[obs_nums.size()-1] !== 8'd255) begin errors++; $display("FAIL full_last got %0d want 255", obs_nums[obs_nums.size()-1]); end
    checks++; if (obs_done_at != 257 || obs_idle_at != 258) begin errors++; $display("FAIL full_timing got done=%0d idle=%0d want 257/258", obs_done_at, obs_idle_at); end
    checks++; if (obs_even !== 9'd128 || obs_odd !== 9'd128) begin errors++; $display("FAIL full_cnts got %0d/%0d want 128/128", obs_even, obs_odd); end
    checks++; if (chk_num !== 8'd255) begin errors++; $display("FAIL full_nowrap got %0d want 255", chk_num); end
  endtask

  task automatic test_lo_gt_hi;
    sweep(10, 3, 0, 0, 0, 0);
    checks++; if (obs_nums.size() != 0) begin errors++; $display("FAIL err_valid got %0d want 0", obs_nums.size()); end
    checks++; if (obs_done_at != 1 || obs_idle_at != 2) begin errors++; $display("FAIL err_timing got done=%0d idle=%0d want 1/2", obs_done_at, obs_idle_at); end
    checks++; if (obs_err !== 1'b1 || obs_even !== 9'd0 || obs_odd !== 9'd0) begin errors++; $display("FAIL err_state got err=%0d %0d/%0d want err=1 0/0", obs_err, obs_even, obs_odd); end
    repeat (2) @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_hold got %0d want 1", err); end
  endtask

  task automatic test_abort;
    sweep(0, 9, 3, 0, 0, 0);
    checks++; if (obs_nums.size() != 3 || obs_done_n != 0 || obs_idle_at != 4) begin errors++; $display("FAIL abort_run got len=%0d done=%0d idle=%0d want 3/0/4", obs_nums.size(), obs_done_n, obs_idle_at); end
    checks++; if (obs_even !== 9'd2 || obs_odd !== 9'd1) begin errors++; $display("FAIL abort_cnts got %0d/%0d want 2/1", obs_even, obs_odd); end
    sweep(4, 5, 0, 0, 1, 0);
    checks++; if (obs_even !== 9'd1 || obs_odd !== 9'd1 || obs_err !== 1'b0 || obs_done_n != 1) begin errors++; $display("FAIL abort_restart got %0d/%0d err=%0d done=%0d want 1/1 err=0 done=1", obs_even, obs_odd, obs_err, obs_done_n); end
    sweep(20, 23, 4, 0, 0, 0);
    checks++; if (obs_nums.size() != 4 || obs_done_n != 0 || obs_idle_at != 5) begin errors++; $display("FAIL abort_last got len=%0d done=%0d idle=%0d want 4/0/5", obs_nums.size(), obs_done_n, obs_idle_at); end
    checks++; if (obs_even !== 9'd2 || obs_odd !== 9'd2) begin errors++; $display("FAIL abort_last_cnts got %0d/%0d want 2/2", obs_even, obs_odd); end
  endtask

  task automatic test_reset_mid_run;
    int seen_done;
    seen_done = 0;
    @(negedge clk);
    start = 1;
    lo = 8'd0;
    hi = 8'd9;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = k == 2 || k == 3;
      lo = 8'd5;
      hi = 8'd6;
      checks++; if (chk_valid !== 1'b1 || chk_num !== W'(k - 1)) begin errors++; $display("FAIL rmid_num%0d got v=%0d num=%0d want v=1 num=%0d", k, chk_valid, chk_num, k - 1); end
    end
    reset = 1;
    start = 1;
    abort = 1;
    @(negedge clk);
    reset = 0;
    start = 0;
    abort = 0;
    checks++; if ({chk_num, chk_valid, busy, done, err, even_cnt, odd_cnt} !== '0) begin errors++; $display("FAIL rmid_outs got %h want 0", {chk_num, chk_valid, busy, done, err, even_cnt, odd_cnt}); end
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen_done++;
    end
    checks++; if (seen_done != 0) begin errors++; $display("FAIL rmid_quiet got %0d want 0", seen_done); end
  endtask

  task automatic test_random;
    int l, h, ab;
    for (int it = 0; it < 25; it++) begin
      l = $urandom_range(0, 255);
      h = l + $urandom_range(0, 12);
      if (h > 255) h = 255;
      if (l > 0 && $urandom_range(0, 4) == 0) h = $urandom_range(0, l - 1);
      ab = (l <= h && $urandom_range(0, 2) == 0) ? $urandom_range(1, h - l + 1) : 0;
      model(l, h, ab);
      sweep(l, h, ab, 1, $urandom_range(0, 1), 0);
      checks++; if (obs_timeout !== 0 || obs_idle_at != exp_idle_at) begin errors++; $display("FAIL rand%0d_idle got %0d want %0d", it, obs_idle_at, exp_idle_at); end
      checks++; if (obs_done_at != exp_done_at || obs_done_n != (exp_done_at != 0 ? 1 : 0)) begin errors++; $display("FAIL rand%0d_done got at=%0d n=%0d want at=%0d", it, obs_done_at, obs_done_n, exp_done_at); end
      checks++; if (obs_nums.size() != exp_nums.size()) begin errors++; $display("FAIL rand%0d_len got %0d want %0d", it, obs_nums.size(), exp_nums.size()); end
      for (int i = 0; i < obs_nums.size() && i < exp_nums.size(); i++) begin
        checks++; if (obs_nums[i] !== exp_nums[i]) begin errors++; $display("FAIL rand%0d_num[%0d] got %0d want %0d", it, i, obs_nums[i], exp_nums[i]); end
      end
      checks++; if (obs_even !== exp_even || obs_odd !== exp_odd || obs_err !== exp_err) begin errors++; $display("FAIL rand%0d_cnts got %0d/%0d err=%0d want %0d/%0d err=%0d", it, obs_even, obs_odd, obs_err, exp_even, exp_odd, exp_err); end
      checks++; if (obs_bad_flags != 0) begin errors++; $display("FAIL rand%0d_flags got %0d want 0", it, obs_bad_flags); end
    end
  endtask

  task automatic test_back_to_back;
    sweep(100, 103, 0, 0, 0, 0);
    model(1, 4, 0);
    sweep(1, 4, 0, 0, 0, 1);
    checks++; if (obs_nums.size() != 4 || obs_nums.size() == 4 && obs_nums[0] !== 8'd1) begin errors++; $display("FAIL b2b_nums got len=%0d want 4 from 1", obs_nums.size()); end
    checks++; if (obs_done_at != exp_done_at || obs_even !== exp_even || obs_odd !== exp_odd) begin errors++; $display("FAIL b2b_result got done=%0d %0d/%0d want done=%0d %0d/%0d", obs_done_at, obs_even, obs_odd, exp_done_at, exp_even, exp_odd); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_single;
    test_full;
    test_lo_gt_hi;
    test_abort;
    test_reset_mid_run;
    test_random;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/even_sweep_ctrl.md
EVEN_SWEEP_CTRL -- requirements
Module: even_sweep_ctrl

Interface
REQ-001 Parameter: W, 8, data width of the checked number.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request a sweep; sampled only in IDLE.
REQ-005 Port: lo  input  W  first number of the sweep; latched when start is accepted.
REQ-006 Port: hi  input  W  last number of the sweep; latched when start is accepted.
REQ-007 Port: abort  input  1  cancel a sweep in progress.
REQ-008 Port: chk_num  output  W  number presented to the external even checker.
REQ-009 Port: chk_valid  output  1  high when chk_num is being evaluated.
REQ-010 Port: chk_result  input  1  combinational checker reply for chk_num in the same cycle; 1 = even, 0 = odd.
REQ-011 Port: busy  output  1  high in RUN.
REQ-012 Port: done  output  1  one-cycle pulse at sweep completion.
REQ-013 Port: err  output  1  lo > hi on the last accepted start.
REQ-014 Port: even_cnt  output  W+1  count of even results.
REQ-015 Port: odd_cnt  output  W+1  count of odd results.

Function
REQ-016 FSM states: IDLE, RUN, DONE; all outputs are registered or decoded from registered state.
REQ-017 IDLE with start=1 and lo<=hi: latch lo/hi, set cur=lo, clear both counters, clear err, go to RUN.
REQ-018 IDLE with start=1 and lo>hi: clear counters, set err=1, go to DONE directly (no RUN cycles).
REQ-019 RUN: chk_num=cur, chk_valid=1, busy=1; even_cnt increments if chk_result=1, otherwise odd_cnt increments; exactly one counter changes per RUN cycle.
REQ-020 RUN with cur==hi_latched: go to DONE; cur is not incremented, so hi=2^W-1 never wraps.
REQ-021 RUN with cur!=hi_latched: cur increments by 1 and the FSM stays in RUN.
REQ-022 Latency: start accepted in cycle T; RUN occupies cycles T+1..T+N with N=hi-lo+1; done=1 only in cycle T+N+1; the FSM is in IDLE at T+N+2.
REQ-023 DONE: done=1, busy=0, chk_valid=0; unconditional transition to IDLE; start is ignored in DONE.
REQ-024 start is ignored in RUN and DONE; lo/hi changes after acceptance have no effect.
REQ-025 abort=1 in RUN: go to IDLE next cycle, done is not asserted, the counter update for that cycle still occurs, and counters then hold their partial values.
REQ-026 abort is ignored in IDLE and DONE; when abort and the final-cycle condition coincide, abort wins and done is not asserted.
REQ-027 even_cnt, odd_cnt and err hold their values in IDLE until the next accepted start.
REQ-028 chk_num holds its last value outside RUN; consumers qualify it with chk_valid.
REQ-029 Counters are W+1 bits wide, so a full 2^W sweep cannot overflow them.

Reset
REQ-030 reset=1 at any clock edge, including mid-RUN: state=IDLE, cur=0, chk_num=0, chk_valid=0, busy=0, done=0, err=0, even_cnt=0, odd_cnt=0.
REQ-031 reset has priority over start and abort in the same cycle; no done pulse is produced by a reset.

Verification
REQ-032 Connect the bench to an LSB-based even checker; lo=0, hi=9, start for 1 cycle -> 10 RUN cycles with chk_num 0..9, done 11 cycles after start, even_cnt=5, odd_cnt=5, err=0.
REQ-033 lo=hi=7 -> 1 RUN cycle, even_cnt=0, odd_cnt=1, done 2 cycles after start.
REQ-034 lo=0, hi=255 -> 256 RUN cycles, last chk_num=255, no wrap to 0, even_cnt=128, odd_cnt=128.
REQ-035 lo=10, hi=3 -> no chk_valid, err=1, done in the cycle after start, counters=0.
REQ-036 lo=0, hi=9, abort in the 3rd RUN cycle -> IDLE next cycle, no done, even_cnt=2, odd_cnt=1; a new start with lo=4, hi=5 -> even_cnt=1, odd_cnt=1, err=0.
REQ-037 reset during the 5th RUN cycle of a lo=0, hi=9 sweep, and start pulses during RUN -> all outputs at reset values next cycle; the start pulses sent during RUN are ignored.
